// File: rtl/shift_reg_ctrl_pkg.sv
// Shared encodings and width helper for the shift register command sequencer.
package shift_reg_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP        = 2'b00,
    OP_SHIFT_BYTE = 2'b01,
    OP_FILL       = 2'b10,
    OP_CLEAR      = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Counter width: wide enough for MSB, never narrower than a FILL length.
  function automatic int cnt_w(input int msb);
    int w;
    w = $clog2(msb + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q < max_i)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/shift_reg_ctrl.sv
// Expands byte-wide commands into bursts of single-bit shifts for shift_reg.
// All shift_reg-facing outputs come straight from flops so they never glitch.
module shift_reg_ctrl
  import shift_reg_ctrl_pkg::*;
#(
  parameter  int MSB   = 32,
  localparam int CNT_W = cnt_w(MSB)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_data,
  input  logic             pause,
  output logic             sr_d,
  output logic             sr_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] level,
  output logic [1:0]       dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so nothing is taken while a burst or DONE is pending.

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             sr_en_q, sr_en_d;
  logic             sr_d_q, sr_d_d;
  logic [CNT_W-1:0] len;
  logic [7:0]       init;
  logic             fill_bit;
  logic             lvl_clr;

  // data_q[0] always holds the next bit to emit; FILL refills with ones from the top.
  assign fill_bit = (op_q == OP_FILL);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sr_en_d = 1'b0;
    sr_d_d  = 1'b0;
    len     = '0;
    init    = '0;
    case (cmd_op)
      OP_SHIFT_BYTE: begin len = CNT_W'(8);        init = cmd_data; end
      OP_FILL:       begin len = CNT_W'(cmd_data); init = 8'hFF;    end
      OP_CLEAR:      begin len = CNT_W'(MSB);      init = 8'h00;    end
      default:       begin len = '0;               init = 8'h00;    end
    endcase
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d = op_e'(cmd_op);
          if (len != '0) begin
            state_d = SHIFT;
            cnt_d   = len;
            sr_en_d = 1'b1;
            sr_d_d  = init[0];
            data_d  = {(cmd_op == OP_FILL), init[7:1]};
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        cnt_d = cnt_q - CNT_W'(sr_en_q);
        if (sr_en_q && (cnt_q == CNT_W'(1))) begin
          state_d = DONE;
        end else if (pause) begin
          sr_d_d = sr_d_q;
        end else begin
          sr_en_d = 1'b1;
          sr_d_d  = data_q[0];
          data_d  = {fill_bit, data_q[7:1]};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      data_q  <= '0;
      sr_en_q <= 1'b0;
      sr_d_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sr_en_q <= sr_en_d;
      sr_d_q  <= sr_d_d;
    end
  end

  // Clearing on entry to DONE makes level read 0 during the CLEAR's DONE cycle.
  assign lvl_clr = (state_d == DONE) && (op_d == OP_CLEAR);

  sat_counter #(.W(CNT_W)) u_level (
    .clk     (clk),
    .rstn    (rstn),
    .clr_i   (lvl_clr),
    .inc_i   (sr_en_q),
    .max_i   (CNT_W'(MSB)),
    .count_o (level)
  );

  assign sr_en     = sr_en_q;
  assign sr_d      = sr_d_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign cmd_ready = (state_q == IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed bench for shift_reg_ctrl with a downstream shift register model.
module tb_shift_reg_ctrl;

  localparam int MSB = 32;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       pause = 1'b0;
  logic       cmd_ready, sr_d, sr_en, busy, done;
  logic [7:0] level;
  logic [1:0] dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;
  int en_cnt = 0;
  logic [MSB-1:0] sr_model = '0;
  logic [0:0] exp_q[$];

  shift_reg_ctrl #(.MSB(MSB)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .pause     (pause),
    .sr_d      (sr_d),
    .sr_en     (sr_en),
    .busy      (busy),
    .done      (done),
    .level     (level),
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every sr_en pulse consumes one expected serial bit
  always @(negedge clk) begin
    if (rstn && sr_en) begin
      en_cnt++;
      sr_model = {sr_model[MSB-2:0], sr_d};
      if (exp_q.size() == 0) check("sr_en_extra", 32'(sr_en), 32'd0);
      else check("sr_d", 32'(sr_d), 32'(exp_q.pop_front()));
    end
  end

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
  endtask

  task automatic push_n(input logic v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] data);
    int n;
    n = 0;
    en_cnt = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    base = cyc;
  endtask

  task automatic wait_done(input string tag, input int exp_rel, input int exp_pulses,
                           input logic [7:0] exp_level);
    int  n;
    int  rel;
    bit  found;
    n = 0; rel = 0; found = 1'b0;
    while (!found && n < 500) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        rel = cyc - base + 1;
      end
      n++;
    end
    check({tag, "_done_seen"}, 32'(found), 32'd1);
    check({tag, "_done_cycle"}, 32'(rel), 32'(exp_rel));
    check({tag, "_pulses"}, 32'(en_cnt), 32'(exp_pulses));
    check({tag, "_level"}, 32'(level), 32'(exp_level));
    check({tag, "_ready_in_done"}, 32'(cmd_ready), 32'd0);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_sr_en"}, 32'(sr_en), 32'd0);
    check({tag, "_sr_d"}, 32'(sr_d), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rstn = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // SHIFT_BYTE 0xA5: LSB first, done at T+9
    push_byte(8'hA5);
    send(2'b01, 8'hA5);
    wait_done("sb_a5", 9, 8, 8'd8);
    check("sb_a5_out", 32'(sr_model[7:0]), 32'hA5);

    // FILL 40: level saturates at MSB, register all ones
    push_n(1'b1, 40);
    send(2'b10, 8'd40);
    wait_done("fill40", 41, 40, 8'd32);
    check("fill40_out", sr_model, 32'hFFFF_FFFF);

    // CLEAR: MSB zero shifts, level 0 already in DONE
    push_n(1'b0, MSB);
    send(2'b11, 8'h00);
    wait_done("clear", MSB + 1, MSB, 8'd0);
    check("clear_out", sr_model, 32'h0);

    // SHIFT_BYTE 0x0F with three paused cycles
    push_byte(8'h0F);
    send(2'b01, 8'h0F);
    @(negedge clk);
    @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    check("pause_en_low", 32'(sr_en), 32'd0);
    check("pause_busy", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    pause = 1'b0;
    wait_done("sb_0f_pause", 12, 8, 8'd8);
    check("sb_0f_out", 32'(sr_model[7:0]), 32'hF0);

    // FILL 0 then NOP held valid back-to-back
    send(2'b10, 8'd0);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;
    @(negedge clk);
    check("fill0_done_t1", 32'(done), 32'd1);
    check("fill0_ready_t1", 32'(cmd_ready), 32'd0);
    check("fill0_level", 32'(level), 32'd8);
    @(negedge clk);
    check("fill0_ready_t2", 32'(cmd_ready), 32'd1);
    check("fill0_done_t2", 32'(done), 32'd0);
    check("fill0_pulses", 32'(en_cnt), 32'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    base = cyc;
    wait_done("nop", 1, 0, 8'd8);

    // reset in the middle of FILL 100
    push_n(1'b1, 100);
    send(2'b10, 8'd100);
    repeat (10) @(negedge clk);
    check("mid_fill_busy", 32'(busy), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    exp_q.delete();
    sr_model = '0;
    check_reset_outputs("mid_rst");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mid_rst_no_done", 32'(done), 32'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_rst");

    // next command runs normally
    push_byte(8'h3C);
    send(2'b01, 8'h3C);
    wait_done("sb_3c", 9, 8, 8'd8);
    check("sb_3c_out", 32'(sr_model[7:0]), 32'h3C);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_reg_ctrl.md
# shift_reg_ctrl

Command sequencer for the `shift_reg` datapath in the top-level design. It accepts byte-wide commands over a valid/ready handshake and expands each one into a burst of single-bit shifts. It drives the shift register's serial data (`sr_d`) and enable (`sr_en`) inputs, and tracks how many bits have entered the register since the last clear.

## Interface
Parameters:
- `MSB`, default 32: width of the controlled shift register (bits), 1..255.

Ports:
- `clk` in 1: clock, shared with `shift_reg`.
- `rstn` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept a command; high only in IDLE.
- `cmd_op` in 2: 00 NOP, 01 SHIFT_BYTE, 10 FILL, 11 CLEAR.
- `cmd_data` in 8: SHIFT_BYTE payload, or FILL length.
- `pause` in 1: stall shifting while high.
- `sr_d` out 1: serial bit to `shift_reg.d`.
- `sr_en` out 1: shift enable to `shift_reg.en`.
- `busy` out 1: high in SHIFT and DONE.
- `done` out 1: one-cycle pulse at command completion.
- `level` out CNT_W: bits shifted since the last completed CLEAR, saturating at MSB.

## Operation
- Reset values:
  - state IDLE; `cmd_ready`=1; `sr_en`=0; `sr_d`=0; `busy`=0; `done`=0; `level`=0.
  - Internal shift counter and payload register are 0.
- States:
  - IDLE: `cmd_ready`=1. On `cmd_valid`: latch op and data, load length L, go to SHIFT if L>0, else DONE.
  - SHIFT: each unpaused cycle asserts `sr_en`=1 and decrements the counter. Go to DONE after the cycle in which the last bit shifts.
  - DONE: `done`=1 for one cycle, `cmd_ready`=0, then IDLE.
- Length and bit source per op:
  - NOP: L=0.
  - SHIFT_BYTE: L=8, bits `cmd_data[0]` first through `cmd_data[7]`.
  - FILL: L=`cmd_data` (0 to 255), all bits 1. L=0 goes straight to DONE.
  - CLEAR: L=MSB, all bits 0.
- `pause`:
  - Sampled every SHIFT cycle. While high: `sr_en`=0, counter and bit index hold, `sr_d` holds.
  - Ignored in IDLE and DONE.
- `level`:
  - Increments by 1 on every cycle with `sr_en`=1, saturating at MSB.
  - Set to 0 in the DONE cycle of a CLEAR.
  - Never wraps.
- Widths: CNT_W = max(8, clog2(MSB+1)). Counter arithmetic is unsigned with no wrap. FILL lengths larger than MSB are legal; the surplus shifts only push ones through.
- Outputs `sr_d`, `sr_en`, `busy`, `done`, `cmd_ready` are functions of registered state only, with no combinational path from inputs. This keeps `shift_reg` glitch-free.
- Reset mid-command:
  - The command is aborted and all outputs return to reset values immediately.
  - No `done` pulse is issued.
  - The top level ties `shift_reg.rstn` to the same reset, so register contents and `level`=0 stay consistent.

## Timing
- Accept at edge T (IDLE with `cmd_valid`=1).
- With no pause, `sr_en` is high for cycles T+1..T+L.
- `done` is high in cycle T+L+1, and `cmd_ready` returns high in T+L+2.
- L=0 case: `done` at T+1, `cmd_ready` at T+2.
- Each paused cycle adds exactly one cycle to the burst.
- `cmd_valid` held high through `done` is not accepted until `cmd_ready`=1. Back-to-back commands therefore have one idle gap cycle.
- `sr_d` is valid in the same cycle as its `sr_en` pulse. `shift_reg` captures it at the end of that cycle.

## Structure
- Shared package `shift_reg_ctrl_pkg`: op encodings (`OP_NOP`, `OP_SHIFT_BYTE`, `OP_FILL`, `OP_CLEAR`), state enum (IDLE/SHIFT/DONE), and the CNT_W function.
- One sub-module, `sat_counter`: CNT_W-wide saturating up-counter with clear, used for `level`.
- The FSM, shift counter and payload shifter are inline.

## Test plan
- Reset, then SHIFT_BYTE with `cmd_data`=0xA5 → `sr_d` sequence 1,0,1,0,0,1,0,1 over 8 `sr_en` cycles; `done` at T+9; `shift_reg.out[7:0]`=0xA5 (bit-reversed per shift direction check); `level`=8.
- FILL 40 with MSB=32 → 40 `sr_en` cycles with `sr_d`=1; `level` saturates at 32; `out`=0xFFFFFFFF.
- CLEAR after FILL → 32 zero shifts; `level`=0 in the DONE cycle; `out`=0.
- SHIFT_BYTE 0x0F with `pause` high for 3 cycles mid-burst → 8 `sr_en` pulses total; `done` at T+12; data order intact.
- FILL 0, then NOP → each gives `done` at T+1 with no `sr_en`; `cmd_ready` low exactly T+1..T+1; back-to-back `cmd_valid` accepted at T+2.
- `rstn` low mid-FILL 100 → outputs at reset values in the same cycle; no `done`; `level`=0; next command runs normally.
